// File: rtl/ps2_host_tx_if.sv
// Command handshake between the input block and the PS/2 host transmitter.
// master issues bytes, slave (the transmitter) reports busy/done/error.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data, tx_start,
        input  busy, done, error
    );

    modport slave (
        input  tx_data, tx_start,
        output busy, done, error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter over open-collector clock/data.
// Define PS2_TX_RETRY_EN to retry a failed frame once before error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 6000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int BIT_TIMEOUT_CYCLES   = 100000
) (
    input  logic          Clock,
    input  logic          Reset_n,
    ps2_host_tx_if.slave  host,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

`ifdef PS2_TX_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif

    localparam int M1 = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                        INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MaxLim = (M1 > BIT_TIMEOUT_CYCLES) ? M1 : BIT_TIMEOUT_CYCLES;
    localparam int CW = $clog2(MaxLim + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND,
        S_WAIT_ACK, S_WAIT_IDLE, S_FAIL
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_fe_q, seen_fe_d;
    logic          data_low_q, data_low_d;
    logic          retry_q, retry_d;

    logic          clk_s, data_s, fe, timeout, retry_now;
    logic [CW-1:0] limit;

    assign clk_s     = clk_sync_q[1];
    assign data_s    = data_sync_q[1];
    assign fe        = clk_prev_q & ~clk_s;
    assign retry_now = RetryEn && !retry_q;
    assign limit     = seen_fe_q ? CW'(BIT_TIMEOUT_CYCLES - 1)
                                 : CW'(START_TIMEOUT_CYCLES - 1);
    assign timeout   = (cnt_q == limit);

    // Two-stage synchronizers plus previous clock level for edge detect
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        clk_prev_d  = clk_s;
    end

    // State and datapath registers; lines idle released, syncs idle high
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            frame_q     <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            seen_fe_q   <= 1'b0;
            data_low_q  <= 1'b0;
            retry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            frame_q     <= frame_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            seen_fe_q   <= seen_fe_d;
            data_low_q  <= data_low_d;
            retry_q     <= retry_d;
        end
    end

    // Next-state: frame sequencing, per-edge shifting and timeouts
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q + CW'(1);
        seen_fe_d  = seen_fe_q;
        data_low_d = data_low_q;
        retry_d    = retry_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (host.tx_start) begin
                    frame_d = {1'b1, ~^host.tx_data, host.tx_data};
                    retry_d = 1'b0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d      = '0;
                    data_low_d = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d     = '0;
                bit_d     = '0;
                seen_fe_d = 1'b0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (fe) begin
                    cnt_d      = '0;
                    seen_fe_d  = 1'b1;
                    data_low_d = ~frame_q[bit_q];
                    bit_d      = bit_q + 4'd1;
                    if (bit_q == 4'd9) state_d = S_WAIT_ACK;
                end else if (timeout) begin
                    state_d = S_FAIL;
                end
            end
            S_WAIT_ACK: begin
                if (fe) begin
                    cnt_d   = '0;
                    state_d = data_s ? S_FAIL : S_WAIT_IDLE;
                end else if (timeout) begin
                    state_d = S_FAIL;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    state_d = S_IDLE;
                end else if (fe) begin
                    cnt_d = '0;
                end else if (timeout) begin
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                cnt_d      = '0;
                data_low_d = 1'b0;
                if (retry_now) begin
                    retry_d = 1'b1;
                    state_d = S_INHIBIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: line drivers only pull low, status decoded from state
    always_comb begin
        ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
        ps2_data_oe = data_low_q &&
                      ((state_q == S_REQ) || (state_q == S_SEND) ||
                       (state_q == S_WAIT_ACK));
        host.busy   = (state_q != S_IDLE);
        host.done   = (state_q == S_WAIT_IDLE) && clk_s && data_s;
        host.error  = (state_q == S_FAIL) && !retry_now;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device.
// Timing parameters are scaled down to keep runs short.
module tb_ps2_host_tx;
    localparam int INH = 100;
    localparam int STO = 2000;
    localparam int BTO = 500;

    logic Clock = 1'b0;
    logic Reset_n = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_in, ps2_data_in, clk_oe, data_oe;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fe_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    ps2_host_tx_if hif ();

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .START_TIMEOUT_CYCLES(STO),
        .BIT_TIMEOUT_CYCLES  (BTO)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .host       (hif),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (clk_oe),
        .ps2_data_oe(data_oe)
    );

    always #5 Clock = ~Clock;

    assign ps2_clk_in  = dev_clk & ~clk_oe;
    assign ps2_data_in = dev_data & ~data_oe;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (hif.done) done_cnt <= done_cnt + 1;
        if (hif.error) err_cnt <= err_cnt + 1;
        if (hif.done && hif.error) both_cnt <= both_cnt + 1;
    end

    // Device: waits for request-to-send, clocks 11 edges, reads bits
    // on rising edges, answers ACK (ack=1) or leaves data high.
    task automatic dev_run(input bit ack, input int stop_fe,
                           output logic [9:0] got, output bit seen);
        int n;
        int h;
        got = '0;
        h = $urandom_range(8, 25);
        n = 0;
        while (!(data_oe && !clk_oe) && n < INH + 400) begin
            @(negedge Clock);
            n++;
        end
        seen = data_oe && !clk_oe;
        if (!seen) return;
        repeat ($urandom_range(5, 40)) @(negedge Clock);
        for (int i = 0; i < 11; i++) begin
            if (i == stop_fe) return;
            dev_clk = 1'b0;
            fe_cyc = cyc;
            repeat (h) @(negedge Clock);
            dev_clk = 1'b1;
            if (i < 10) got[i] = ps2_data_in;
            if (i == 9) begin
                repeat (2) @(negedge Clock);
                dev_data = !ack;
                repeat (h - 2) @(negedge Clock);
            end else begin
                repeat (h) @(negedge Clock);
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        hif.tx_start = 1'b0;
        hif.tx_data = 8'h00;
        repeat (3) @(negedge Clock);
        checks++;
        if (clk_oe !== 1'b0) begin
            errors++; $display("FAIL reset_clk_oe: got %b expected 0", clk_oe);
        end
        checks++;
        if (data_oe !== 1'b0) begin
            errors++; $display("FAIL reset_data_oe: got %b expected 0", data_oe);
        end
        checks++;
        if (hif.done !== 1'b0 || hif.error !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got done=%b error=%b expected 0 0",
                     hif.done, hif.error);
        end
        Reset_n = 1'b1;
        @(negedge Clock);
        checks++;
        if (hif.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", hif.busy);
        end
    endtask

    task automatic test_byte(input logic [7:0] b, input bit dup_en,
                             input logic [7:0] dup);
        logic [9:0] exp;
        logic [9:0] got;
        bit seen;
        int d0, e0, n, inh;
        exp = {1'b1, ($countones(b) % 2 == 0), b};
        d0 = done_cnt;
        e0 = err_cnt;
        hif.tx_data = b;
        hif.tx_start = 1'b1;
        @(negedge Clock);
        hif.tx_start = 1'b0;
        inh = 0;
        n = 0;
        while (!data_oe && n < INH + 50) begin
            if (clk_oe) inh++;
            @(negedge Clock);
            n++;
            hif.tx_start = dup_en && (n == 5);
            if (dup_en && n == 5) hif.tx_data = dup;
        end
        hif.tx_start = 1'b0;
        checks++;
        if (inh !== INH) begin
            errors++; $display("FAIL inhibit_len %h: got %0d expected %0d", b, inh, INH);
        end
        dev_run(1'b1, 11, got, seen);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL release %h: got none expected release", b);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL bit%0d of %h: got %b expected %b", i, b, got[i], exp[i]);
            end
        end
        n = 0;
        while (hif.busy && n < 200) begin
            @(negedge Clock);
            n++;
        end
        @(negedge Clock);
        checks++;
        if (hif.busy !== 1'b0) begin
            errors++; $display("FAIL busy_end %h: got %b expected 0", b, hif.busy);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++; $display("FAIL done_cnt %h: got %0d expected 1", b, done_cnt - d0);
        end
        checks++;
        if (err_cnt !== e0) begin
            errors++; $display("FAIL no_error %h: got %0d expected 0", b, err_cnt - e0);
        end
    endtask

    task automatic test_nack();
        logic [9:0] got;
        bit seen;
        int d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        hif.tx_data = 8'hFF;
        hif.tx_start = 1'b1;
        @(negedge Clock);
        hif.tx_start = 1'b0;
        dev_run(1'b0, 11, got, seen);
`ifdef PS2_TX_RETRY_EN
        checks++;
        if (err_cnt !== e0) begin
            errors++; $display("FAIL nack_first: got %0d errors expected 0", err_cnt - e0);
        end
        dev_run(1'b0, 11, got, seen);
`endif
        checks++;
        if (!seen) begin
            errors++; $display("FAIL nack_release: got none expected release");
        end
        n = 0;
        while (hif.busy && n < 400) begin
            @(negedge Clock);
            n++;
        end
        @(negedge Clock);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++; $display("FAIL nack_error: got %0d expected 1", err_cnt - e0);
        end
        checks++;
        if (done_cnt !== d0) begin
            errors++; $display("FAIL nack_done: got %0d expected 0", done_cnt - d0);
        end
    endtask

    task automatic test_start_timeout();
        int d0, e0, n, rel, d;
        d0 = done_cnt;
        e0 = err_cnt;
        hif.tx_data = 8'hF4;
        hif.tx_start = 1'b1;
        @(negedge Clock);
        hif.tx_start = 1'b0;
        n = 0;
        while (!(data_oe && !clk_oe) && n < INH + 50) begin
            @(negedge Clock);
            n++;
        end
        rel = cyc;
        n = 0;
        while (!hif.error && n < STO + 50) begin
            @(negedge Clock);
            n++;
        end
        d = cyc - rel;
        checks++;
        if (!hif.error || d < STO - 2 || d > STO + 2) begin
            errors++;
            $display("FAIL start_timeout: got %0d cycles expected %0d", d, STO);
        end
        @(negedge Clock);
        checks++;
        if (clk_oe !== 1'b0 || data_oe !== 1'b0 || hif.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_to_release: got %b%b%b expected 000",
                     clk_oe, data_oe, hif.busy);
        end
        checks++;
        if (err_cnt - e0 !== 1 || done_cnt !== d0) begin
            errors++;
            $display("FAIL start_to_pulses: got err=%0d done=%0d expected 1 0",
                     err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_bit_timeout();
        logic [9:0] got;
        logic [7:0] b;
        bit seen;
        int e0, n, d;
        b = 8'($urandom);
        e0 = err_cnt;
        hif.tx_data = b;
        hif.tx_start = 1'b1;
        @(negedge Clock);
        hif.tx_start = 1'b0;
        dev_run(1'b1, 4, got, seen);
        checks++;
        if (got[3:0] !== b[3:0]) begin
            errors++; $display("FAIL stall_bits: got %h expected %h", got[3:0], b[3:0]);
        end
        n = 0;
        while (!hif.error && n < BTO + 50) begin
            @(negedge Clock);
            n++;
        end
        d = cyc - fe_cyc;
        checks++;
        if (!hif.error || d < BTO - 4 || d > BTO + 4) begin
            errors++;
            $display("FAIL bit_timeout: got %0d cycles expected %0d", d, BTO);
        end
        @(negedge Clock);
        checks++;
        if (clk_oe !== 1'b0 || data_oe !== 1'b0 || err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL bit_to_release: got oe=%b%b err=%0d expected 00 1",
                     clk_oe, data_oe, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        hif.tx_data = 8'hED;
        hif.tx_start = 1'b1;
        @(negedge Clock);
        hif.tx_start = 1'b0;
        n = 0;
        while (!data_oe && n < INH + 50) begin
            @(negedge Clock);
            n++;
        end
        checks++;
        if (data_oe !== 1'b1 || clk_oe !== 1'b1) begin
            errors++;
            $display("FAIL req_lines: got %b%b expected 11", clk_oe, data_oe);
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin
            errors++;
            $display("FAIL async_release: got %b%b expected 00", clk_oe, data_oe);
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if (hif.busy !== 1'b0 || clk_oe !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got busy=%b clk_oe=%b expected 0 0",
                     hif.busy, clk_oe);
        end
    endtask

    initial begin
        test_reset();
        test_byte(8'hED, 1'b0, 8'h00);
        test_byte(8'hF4, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            test_byte(8'($urandom), 1'b0, 8'h00);
        end
        test_byte(8'h5A, 1'b1, 8'hA5);
        test_nack();
        test_start_timeout();
        test_bit_timeout();
        test_reset_mid();
        checks++;
        if (both_cnt !== 0) begin
            errors++; $display("FAIL done_and_error: got %0d expected 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
